evict_wb_buffer: RTL and testbench

EVICT_WB_BUFFER -- requirements
Module: evict_wb_buffer

---
 rtl/cache_pkg.sv | 13 +
 rtl/victim_fifo.sv | 50 +++++
 rtl/evict_wb_buffer.sv | 107 ++++++++++
 tb/tb_evict_wb_buffer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache-side types: write-back FSM states and counter widths.
// Imported by the eviction write-back buffer and other cache blocks.
package cache_pkg;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_REQ      = 2'd1,
        WB_ACK_WAIT = 2'd2
    } wb_state_e;

    localparam int DROP_W = 16;

endpackage

// File: rtl/victim_fifo.sv
// Victim queue: circular storage with head/tail pointers and occupancy.
// Ports: push_i/data_i write tail, pop_i advances head, data_o = head, count_o.
module victim_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    // Storage needs no reset; occupancy tracking decides validity.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[tail_q] <= data_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i)  head_q <= head_q + 1'b1;
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/evict_wb_buffer.sv
// Eviction write-back buffer: queues nonzero evicted addresses, issues them
// as wb requests (valid/ready then ack), retries on ack timeout, counts drops.
// Ports: clk, reset (async active-low), evicted_address, wb_valid/wb_addr/
// wb_ready/wb_ack, full, empty, count, drop_count, timeout_err.
module evict_wb_buffer
    import cache_pkg::*;
#(
    parameter  int DEPTH       = 4,
    parameter  int ADDR_WIDTH  = 8,
    parameter  int ACK_TIMEOUT = 15,
    localparam int CW          = $clog2(DEPTH) + 1,
    localparam int TW          = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] evicted_address,
    output logic                  wb_valid,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic                  wb_ready,
    input  logic                  wb_ack,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count,
    output logic [DROP_W-1:0]     drop_count,
    output logic                  timeout_err
);

    wb_state_e             state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DROP_W-1:0]     drop_q, drop_d;
    logic                  terr_q, terr_d;
    logic                  evict, push, pop;
    logic [ADDR_WIDTH-1:0] head;

    victim_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .data_i  (evicted_address),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count)
    );

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign evict = (evicted_address != '0);
    // Pop depends only on state and ack, so push may safely depend on it.
    assign pop   = (state_q == WB_ACK_WAIT) && wb_ack;
    assign push  = evict && (!full || pop);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        terr_d  = terr_q;
        drop_d  = drop_q;
        if (evict && !push && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
        unique case (state_q)
            WB_IDLE: begin
                if (!empty) state_d = WB_REQ;
            end
            WB_REQ: begin
                if (wb_ready) begin
                    state_d = WB_ACK_WAIT;
                    timer_d = '0;
                end
            end
            WB_ACK_WAIT: begin
                if (wb_ack) begin
                    // A same-cycle push also counts as a remaining entry.
                    state_d = ((count > CW'(1)) || push) ? WB_REQ : WB_IDLE;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = WB_REQ;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WB_IDLE;
            timer_q <= '0;
            drop_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
            terr_q  <= terr_d;
        end
    end

    assign wb_valid    = (state_q == WB_REQ);
    assign wb_addr     = wb_valid ? head : '0;
    assign drop_count  = drop_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_evict_wb_buffer.sv
// Bench for evict_wb_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_evict_wb_buffer;

    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  evicted_address = '0;
    logic        wb_valid;
    logic [7:0]  wb_addr;
    logic        wb_ready = 1'b0;
    logic        wb_ack = 1'b0;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic [15:0] drop_count;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queue plus a phase (0 idle, 1 request, 2 waiting).
    int unsigned mq[$];
    int          ph;
    int          waited;
    int          drops;
    bit          terr;

    evict_wb_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .evicted_address (evicted_address),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .wb_ready        (wb_ready),
        .wb_ack          (wb_ack),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .drop_count      (drop_count),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        ph     = 0;
        waited = 0;
        drops  = 0;
        terr   = 0;
    endtask

    task automatic model_step(input int unsigned a, input bit r, input bit k);
        int  pre;
        bit  p;
        pre = mq.size();
        p   = (ph == 2) && k;
        if (p) void'(mq.pop_front());
        if (a != 0) begin
            if (pre < DEPTH || p) mq.push_back(a);
            else if (drops < 65535) drops++;
        end
        case (ph)
            0: if (pre > 0) ph = 1;
            1: if (r) begin ph = 2; waited = 0; end
            default: begin
                if (k) ph = (mq.size() > 0) ? 1 : 0;
                else begin
                    waited++;
                    if (waited == TMO) begin terr = 1; ph = 1; end
                end
            end
        endcase
    endtask

    task automatic check_outs();
        int unsigned ea;
        ea = (ph == 1) ? mq[0] : 0;
        chk("wb_valid", 32'(wb_valid), 32'(ph == 1));
        chk("wb_addr", 32'(wb_addr), ea);
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("drop_count", 32'(drop_count), 32'(drops));
        chk("timeout_err", 32'(timeout_err), 32'(terr));
    endtask

    task automatic cyc(input logic [7:0] a, input logic r, input logic k);
        evicted_address = a;
        wb_ready        = r;
        wb_ack          = k;
        @(posedge clk);
        model_step(32'(a), r, k);
        @(negedge clk);
        check_outs();
    endtask

    task automatic do_reset();
        evicted_address = '0;
        wb_ready        = 1'b0;
        wb_ack          = 1'b0;
        reset           = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(negedge clk);
        check_outs();
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single eviction, accepted immediately, acked two cycles later.
        cyc(8'h3C, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0);

        // Overfill with ready low, then drain with ready/ack held high.
        for (int i = 1; i <= 5; i++) cyc(8'(i), 1'b0, 1'b0);
        chk("fill_drop", 32'(drop_count), 32'd1);
        for (int i = 0; i < 12; i++) cyc(8'h00, 1'b1, 1'b1);

        // Push into a full queue in the same cycle as a pop.
        for (int i = 1; i <= 4; i++) cyc(8'(8'h10 + i), 1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h55, 1'b0, 1'b1);
        chk("full_pushpop_count", 32'(count), 32'd4);

        // Withhold ack until timeout; same address must be retried.
        cyc(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < TMO; i++) cyc(8'h00, 1'b0, 1'b0);
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        chk("tmo_retry_addr", 32'(wb_addr), 32'h12);

        // Reset mid-transaction with three entries queued.
        do_reset();
        for (int i = 1; i <= 3; i++) cyc(8'(8'h20 + i), 1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(8'h00, 1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            cyc(a, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
        end

        // Drop counter saturation.
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            cyc(8'($urandom_range(1, 255)), 1'b0, 1'b0);
        end
        chk("drop_sat", 32'(drop_count), 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
